checker_handshake: RTL and testbench
====================================

# checker_handshake

Simulation-side protocol checker for the CPU's valid/ready buses (instruction read, data read, data write). It monitors `CHANNELS` independent channels in parallel and records sticky per-channel errors for dropped valid, payload change while stalled and stall timeout. It also counts completed transfers per channel. It is instantiated next to the core in the testbench, has no effect on DUT behaviour, and optionally terminates simulation on the first error.

## Interface
- `CHANNELS`, 3: number of monitored valid/ready channels (1..16).
- `DATA_WIDTH`, 32: payload width per channel, in bits.
- `TIMEOUT`, 256: consecutive stalled cycles that raise a timeout (2..65535).
- `CNT_WIDTH`, 16: width of each transfer counter.

Ports:
- `clk` input 1: the single clock; all sampling happens on posedge.
- `rst` input 1: asynchronous, active-low reset.
- `enable` input 1: when 0, no checks run and no counters change; state is held.
- `valid` input CHANNELS: per-channel valid.
- `ready` input CHANNELS: per-channel ready.
- `data` input CHANNELS*DATA_WIDTH: payloads; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `fire` output CHANNELS: one-cycle pulse; any error detected on channel i at the last edge.
- `err_drop` output CHANNELS: sticky; valid withdrawn before ready.
- `err_data` output CHANNELS: sticky; payload changed while stalled.
- `err_timeout` output CHANNELS: sticky; stall reached `TIMEOUT`.
- `xfer_count` output CHANNELS*CNT_WIDTH: completed transfers per channel; saturating.

## Operation
- Each channel has its own state machine with states IDLE and STALL, a DATA_WIDTH capture register and a stall counter of width clog2(TIMEOUT+1).
- IDLE:
  - valid&ready: count one transfer; stay in IDLE.
  - valid&~ready: capture data, set stall counter to 1, go to STALL.
  - ~valid: stay in IDLE.
- STALL:
  - ~valid: set err_drop, pulse fire, go to IDLE, clear the stall counter.
  - valid and data != capture: set err_data and pulse fire. Checks continue against the originally captured value; the capture is not updated.
  - valid&ready: count one transfer (the data check above still applies on this edge), go to IDLE, clear the stall counter.
  - valid&~ready: increment the stall counter, saturating at TIMEOUT.
    - The edge on which the counter becomes TIMEOUT sets err_timeout and pulses fire, once per stall.
    - A stall longer than TIMEOUT does not pulse again.
- Several errors on the same channel at one edge produce a single fire pulse; each matching sticky flag is set.
- xfer_count saturates at all-ones and never wraps.
- Channels are fully independent; simultaneous events on different channels are all recorded at the same edge.
- enable=0: the state machine, capture register, stall counter and xfer_count hold their values; fire is 0. Sticky flags hold.

## Timing
- All outputs are registered. An event sampled at edge n is visible after edge n.
- fire is high for exactly one cycle per erroring edge.
- Reset (async assert, sync deassert by the bench):
  - all outputs 0, all channels IDLE, stall counters 0.
  - Reset mid-stall discards the stall: no error is raised.
- Stall length: valid high with ready low for k edges gives stall counter k. A timeout requires TIMEOUT consecutive stalled edges.
- Zero-wait transfers (ready already high when valid rises) never enter STALL.

## Configuration
- `CHECKER_HANDSHAKE_FATAL_EN`:
  - Defined: on any fire pulse, print channel index, error kind(s) and sim time, then end simulation after that edge. The failure is fatal in severity.
  - Undefined: flags and counters only; simulation continues, and the testbench polls the sticky flags at end of test.

## Test plan
- CHANNELS=3, DATA_WIDTH=32, `CHECKER_HANDSHAKE_FATAL_EN` undefined.
- Ch0: five back-to-back valid&ready transfers -> xfer_count[0]=5; no fire; all err flags 0.
- Ch1: valid with data 0xDEADBEEF, ready low for 3 cycles, then ready high with the same data -> xfer_count[1]=1; no errors.
- Ch1 stall: data changes to 0xDEADBEEE on the 2nd stalled cycle -> fire[1] pulses one cycle after that edge; err_data[1]=1 and stays 1.
- Ch2: valid high, ready low 2 cycles, then valid drops with no ready -> err_drop[2]=1, fire[2] one pulse, xfer_count[2]=0.
- TIMEOUT=4, ch0 stalls 10 cycles -> a single fire[0] pulse after the 4th stalled edge; err_timeout[0]=1.
- Assert rst mid-stall on ch1 after 2 cycles -> all outputs 0 asynchronously. After release, the checker restarts cleanly: no errors until new stimulus.

Source files
------------

// File: rtl/checker_handshake.sv
// ============================================================================
// Module      : checker_handshake
// Description : Passive valid/ready protocol checker for CHANNELS independent
//               channels. Records sticky errors for dropped valid, payload
//               change while stalled and stall timeout, pulses fire on any
//               error edge and counts completed transfers (saturating).
//               Optional macro CHECKER_HANDSHAKE_FATAL_EN ends simulation on
//               the first fire pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module checker_handshake #(
    parameter int CHANNELS   = 3,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [CHANNELS-1:0]            valid,
    input  logic [CHANNELS-1:0]            ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data,
    output logic [CHANNELS-1:0]            fire,
    output logic [CHANNELS-1:0]            err_drop,
    output logic [CHANNELS-1:0]            err_data,
    output logic [CHANNELS-1:0]            err_timeout,
    output logic [CHANNELS*CNT_WIDTH-1:0]  xfer_count
);

    // Stall counter must be able to hold the value TIMEOUT itself.
    localparam int             STALL_W     = $clog2(TIMEOUT + 1);
    localparam logic [STALL_W-1:0] C_TIMEOUT = STALL_W'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch

        state_t                 state_q, state_d;
        logic [DATA_WIDTH-1:0]  cap_q,   cap_d;
        logic [STALL_W-1:0]     stall_q, stall_d;
        logic [CNT_WIDTH-1:0]   cnt_q,   cnt_d;
        logic                   fire_q,  fire_d;
        logic                   drop_q,  drop_d;
        logic                   dat_q,   dat_d;
        logic                   to_q,    to_d;

        logic [DATA_WIDTH-1:0]  w_data;
        logic                   w_data_err;
        logic                   w_to_err;

        assign w_data = data[g*DATA_WIDTH +: DATA_WIDTH];

        // Next-state and error detection for one channel.
        always_comb begin
            state_d    = state_q;
            cap_d      = cap_q;
            stall_d    = stall_q;
            cnt_d      = cnt_q;
            drop_d     = drop_q;
            dat_d      = dat_q;
            to_d       = to_q;
            fire_d     = 1'b0;
            w_data_err = 1'b0;
            w_to_err   = 1'b0;

            if (enable) begin
                case (state_q)
                    ST_IDLE: begin
                        if (valid[g] && ready[g]) begin
                            // Zero-wait transfer never enters STALL.
                            if (cnt_q != C_CNT_MAX) begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end else if (valid[g]) begin
                            cap_d   = w_data;
                            stall_d = STALL_W'(1);
                            state_d = ST_STALL;
                        end
                    end

                    ST_STALL: begin
                        if (!valid[g]) begin
                            drop_d  = 1'b1;
                            fire_d  = 1'b1;
                            stall_d = '0;
                            state_d = ST_IDLE;
                        end else begin
                            // Compare against the first captured payload;
                            // capture is never refreshed during a stall.
                            w_data_err = (w_data != cap_q);
                            if (ready[g]) begin
                                if (cnt_q != C_CNT_MAX) begin
                                    cnt_d = cnt_q + 1'b1;
                                end
                                stall_d = '0;
                                state_d = ST_IDLE;
                            end else if (stall_q != C_TIMEOUT) begin
                                stall_d  = stall_q + 1'b1;
                                // Only the edge that reaches TIMEOUT reports;
                                // a saturated counter stays silent.
                                w_to_err = ((stall_q + 1'b1) == C_TIMEOUT);
                            end
                            if (w_data_err) begin
                                dat_d = 1'b1;
                            end
                            if (w_to_err) begin
                                to_d = 1'b1;
                            end
                            fire_d = w_data_err | w_to_err;
                        end
                    end

                    default: begin
                        state_d = ST_IDLE;
                        stall_d = '0;
                    end
                endcase
            end
        end

        // Channel state registers; reset discards any stall silently.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= ST_IDLE;
                cap_q   <= '0;
                stall_q <= '0;
                cnt_q   <= '0;
                fire_q  <= 1'b0;
                drop_q  <= 1'b0;
                dat_q   <= 1'b0;
                to_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                cap_q   <= cap_d;
                stall_q <= stall_d;
                cnt_q   <= cnt_d;
                fire_q  <= fire_d;
                drop_q  <= drop_d;
                dat_q   <= dat_d;
                to_q    <= to_d;
            end
        end

        assign fire[g]                            = fire_q;
        assign err_drop[g]                        = drop_q;
        assign err_data[g]                        = dat_q;
        assign err_timeout[g]                     = to_q;
        assign xfer_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q;

`ifdef CHECKER_HANDSHAKE_FATAL_EN
        // Stop the run on the first reported error, naming channel and kind.
        always @(negedge clk) begin
            if (rst && fire_q) begin
                $fatal(1, "checker_handshake: channel %0d error%s%s%s at %0t",
                       g,
                       (drop_q ? " drop"    : ""),
                       (dat_q  ? " data"    : ""),
                       (to_q   ? " timeout" : ""),
                       $time);
            end
        end
`endif

    end

endmodule

`default_nettype wire

// File: tb/tb_checker_handshake.sv
// ============================================================================
// Module      : tb_checker_handshake
// Description : Self-checking bench for checker_handshake (3 channels,
//               TIMEOUT=4, 4-bit counters). Directed scenarios followed by
//               randomized traffic, compared against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_checker_handshake;

    localparam int CH = 3;
    localparam int DW = 32;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic               clk;
    logic               rst;
    logic               enable;
    logic [CH-1:0]      valid;
    logic [CH-1:0]      ready;
    logic [CH*DW-1:0]   data;
    logic [CH-1:0]      fire;
    logic [CH-1:0]      err_drop;
    logic [CH-1:0]      err_data;
    logic [CH-1:0]      err_timeout;
    logic [CH*CW-1:0]   xfer_count;

    checker_handshake #(
        .CHANNELS   (CH),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO),
        .CNT_WIDTH  (CW)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .valid       (valid),
        .ready       (ready),
        .data        (data),
        .fire        (fire),
        .err_drop    (err_drop),
        .err_data    (err_data),
        .err_timeout (err_timeout),
        .xfer_count  (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model: an offered-but-unaccepted word per channel.
    bit          m_pend [CH];
    logic [31:0] m_hold [CH];
    int          m_len  [CH];
    int          m_cnt  [CH];
    bit          m_fire [CH];
    bit          m_drop [CH];
    bit          m_dat  [CH];
    bit          m_to   [CH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_pend[c] = 0; m_hold[c] = '0; m_len[c] = 0; m_cnt[c] = 0;
            m_fire[c] = 0; m_drop[c] = 0; m_dat[c] = 0; m_to[c] = 0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < CH; c++) begin
            bit v, r, e;
            logic [31:0] d;
            v = valid[c]; r = ready[c]; d = data[c*DW +: DW];
            m_fire[c] = 0;
            if (enable) begin
                e = 0;
                if (!m_pend[c]) begin
                    if (v && r) m_cnt[c] = (m_cnt[c] < CMAX) ? m_cnt[c] + 1 : CMAX;
                    else if (v) begin
                        m_pend[c] = 1; m_hold[c] = d; m_len[c] = 1;
                    end
                end else if (!v) begin
                    m_drop[c] = 1; e = 1; m_pend[c] = 0; m_len[c] = 0;
                end else begin
                    if (d != m_hold[c]) begin m_dat[c] = 1; e = 1; end
                    if (r) begin
                        m_cnt[c] = (m_cnt[c] < CMAX) ? m_cnt[c] + 1 : CMAX;
                        m_pend[c] = 0; m_len[c] = 0;
                    end else if (m_len[c] < TO) begin
                        m_len[c]++;
                        if (m_len[c] == TO) begin m_to[c] = 1; e = 1; end
                    end
                end
                m_fire[c] = e;
            end
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("fire[%0d]", c),        64'(fire[c]),        64'(m_fire[c]));
            chk($sformatf("err_drop[%0d]", c),    64'(err_drop[c]),    64'(m_drop[c]));
            chk($sformatf("err_data[%0d]", c),    64'(err_data[c]),    64'(m_dat[c]));
            chk($sformatf("err_timeout[%0d]", c), 64'(err_timeout[c]), 64'(m_to[c]));
            chk($sformatf("xfer_count[%0d]", c),  64'(xfer_count[c*CW +: CW]), 64'(m_cnt[c]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input int c, input bit v, input bit r, input logic [31:0] d);
        valid[c] = v;
        ready[c] = r;
        data[c*DW +: DW] = d;
    endtask

    task automatic idle_all();
        valid = '0; ready = '0; data = '0;
    endtask

    initial begin
        rst = 1'b0; enable = 1'b1;
        idle_all();
        model_reset();
        #2;
        check_all();                                   // reset state
        @(negedge clk); rst = 1'b1;
        tick();

        // Ch0: five back-to-back zero-wait transfers.
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, $urandom);
            tick();
            chk("ch0_b2b_nofire", 64'(fire[0]), 64'd0);
        end
        drive(0, 0, 0, 0);
        tick();
        chk("ch0_cnt5", 64'(xfer_count[0 +: CW]), 64'd5);

        // Ch1: 3-cycle stall with stable payload, then accept.
        drive(1, 1, 0, 32'hDEADBEEF);
        repeat (3) tick();
        drive(1, 1, 1, 32'hDEADBEEF);
        tick();
        drive(1, 0, 0, 0);
        tick();
        chk("ch1_cnt1", 64'(xfer_count[CW +: CW]), 64'd1);
        chk("ch1_noerr", 64'({err_drop[1], err_data[1], err_timeout[1]}), 64'd0);

        // Ch1: payload changes on 2nd stalled edge.
        drive(1, 1, 0, 32'hDEADBEEF);
        tick();
        drive(1, 1, 0, 32'hDEADBEEE);
        tick();
        chk("ch1_data_fire", 64'(fire[1]), 64'd1);
        chk("ch1_err_data", 64'(err_data[1]), 64'd1);
        drive(1, 1, 0, 32'hDEADBEEF);
        tick();
        chk("ch1_fire_1cyc", 64'(fire[1]), 64'd0);
        drive(1, 1, 1, 32'hDEADBEEF);
        tick();
        drive(1, 0, 0, 0);
        tick();
        chk("ch1_err_data_sticky", 64'(err_data[1]), 64'd1);

        // Ch2: two stalled edges then valid withdrawn.
        drive(2, 1, 0, 32'h1234_5678);
        repeat (2) tick();
        drive(2, 0, 0, 0);
        tick();
        chk("ch2_drop_fire", 64'(fire[2]), 64'd1);
        chk("ch2_err_drop", 64'(err_drop[2]), 64'd1);
        chk("ch2_cnt0", 64'(xfer_count[2*CW +: CW]), 64'd0);
        tick();

        // Ch0: 10-cycle stall; one fire on the 4th stalled edge only.
        drive(0, 1, 0, 32'hCAFE_0000);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("ch0_to_fire_e%0d", i), 64'(fire[0]), 64'(i == TO));
        end
        chk("ch0_err_timeout", 64'(err_timeout[0]), 64'd1);
        drive(0, 1, 1, 32'hCAFE_0000);
        tick();
        drive(0, 0, 0, 0);
        tick();

        // enable=0: activity is ignored and state holds.
        enable = 1'b0;
        drive(1, 1, 0, 32'h5);
        drive(2, 1, 1, 32'h6);
        repeat (3) tick();
        enable = 1'b1;
        idle_all();
        tick();

        // Reset asserted mid-stall on ch1 after two stalled edges.
        drive(1, 1, 0, 32'hABCD_0001);
        repeat (2) tick();
        #3 rst = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_async_flags", 64'({err_drop, err_data, err_timeout, fire}), 64'd0);
        idle_all();
        @(negedge clk); rst = 1'b1;
        repeat (3) tick();
        chk("post_rst_clean", 64'({err_drop, err_data, err_timeout}), 64'd0);

        // Counter saturation on ch0.
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 1, $urandom);
            tick();
        end
        chk("ch0_cnt_sat", 64'(xfer_count[0 +: CW]), 64'(CMAX));
        idle_all();
        tick();

        // Clear state, then randomized traffic on all channels.
        #3 rst = 1'b0;
        model_reset();
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < CH; c++) begin
                bit v, r;
                logic [31:0] d;
                if (m_pend[c]) begin
                    v = ($urandom_range(99) < 90);
                    d = ($urandom_range(99) < 90) ? m_hold[c] : {28'h0, 4'($urandom)};
                end else begin
                    v = ($urandom_range(99) < 60);
                    d = {28'h0, 4'($urandom)};
                end
                r = ($urandom_range(99) < 30);
                drive(c, v, r, d);
            end
            enable = ($urandom_range(99) < 92);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
